// File: rtl/enc_sched_pkg.sv
// Shared definitions for the encoder sample scheduler.
// Contents:
//   state_e      - scheduler FSM states (3-bit encoding, also visible in the status word)
//   ADDR_POS0    - first position register index
//   addr_delta0  - first delta register index for a given channel count
//   addr_status  - status register index for a given channel count
//   STAT_*       - bit positions inside the status word
//   pack_status  - assembles the status word
package enc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    SNAP  = 3'd4
  } state_e;

  localparam int ADDR_POS0      = 0;
  localparam int STAT_SV_BIT    = 0;
  localparam int STAT_OVR_BIT   = 1;
  localparam int STAT_STATE_LSB = 2;
  localparam int STAT_SEQ_LSB   = 16;

  function automatic logic [7:0] addr_delta0(input int num_ch);
    return 8'(num_ch);
  endfunction

  function automatic logic [7:0] addr_status(input int num_ch);
    return 8'(2 * num_ch);
  endfunction

  // Layout: {seq[15:0], 11'b0, state[2:0], overrun, sample_valid}
  function automatic logic [31:0] pack_status(input logic [15:0] seq,
                                              input logic [2:0]  st,
                                              input logic        ovr,
                                              input logic        sv);
    return {seq, 11'd0, st, ovr, sv};
  endfunction

endpackage

// File: rtl/enc_sample_timer.sv
// Shared period / clear-phase counter for the encoder sample scheduler.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_load      - synchronously reload the count to zero (has priority)
//   i_inc       - increment the count by one
//   i_tc_val    - terminal value to compare against
//   o_tc        - high while the count equals i_tc_val
module enc_sample_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_inc,
  input  logic [W-1:0] i_tc_val,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Counter register: load wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= {W{1'b0}};
    end else if (i_inc) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/enc_sample_sched.sv
// Encoder sample scheduler: sequences the decoders' Clr/Start controls, snapshots every
// channel's position word once per sample period, computes per-period deltas and serves
// them through a one-cycle-latency request/ack read port.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   i_en            - level enable; low forces IDLE (results and flags retained)
//   i_enc_dout      - position words, channel i at bits [32i+31:32i]
//   o_enc_start     - Start to every decoder (all bits equal)
//   o_enc_clr_n     - active-low Clr to every decoder (all bits equal)
//   i_rd_req        - single-cycle read request
//   i_rd_addr       - register index: pos[0..N-1], delta[N..2N-1], status at 2N
//   o_rd_data       - read data, valid with o_rd_ack
//   o_rd_ack        - pulse one cycle after i_rd_req
//   o_sample_valid  - unread snapshot available
//   o_overrun       - a snapshot was taken while the previous one was unread
//   o_irq           - one-cycle pulse during each snapshot cycle
module enc_sample_sched
  import enc_sched_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_DIV = 50000,
  parameter int CLR_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [NUM_CH*32-1:0] i_enc_dout,
  output logic [NUM_CH-1:0]    o_enc_start,
  output logic [NUM_CH-1:0]    o_enc_clr_n,
  input  logic                 i_rd_req,
  input  logic [7:0]           i_rd_addr,
  output logic [31:0]          o_rd_data,
  output logic                 o_rd_ack,
  output logic                 o_sample_valid,
  output logic                 o_overrun,
  output logic                 o_irq
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                    r_state;
  logic                      r_start;
  logic                      r_clr_n;
  logic                      r_irq;
  logic [15:0]               r_seq;
  logic                      r_sv;
  logic                      r_ovr;
  logic [31:0]               r_rd_data;
  logic                      r_rd_ack;
  logic                      r_stat_clr;

  logic                      w_timer_load;
  logic                      w_timer_inc;
  logic [31:0]               w_tc_val;
  logic                      w_tc;
  logic                      w_snap;
  logic [NUM_CH-1:0][31:0]   w_pos;
  logic [NUM_CH-1:0][31:0]   w_delta;
  logic [IW-1:0]             w_pidx;
  logic [IW-1:0]             w_didx;
  logic [31:0]               w_rd_mux;

  // The timer is discarded whenever the scheduler is idle or disabled, so a re-enable
  // always starts a fresh clear phase and a fresh period.
  assign w_timer_load = !i_en || (r_state == IDLE) || (r_state == ARM) || (r_state == SNAP);
  assign w_timer_inc  = (r_state == CLEAR) || (r_state == RUN);
  // RUN ends at SAMPLE_DIV-2 so that ARM->first SNAP and SNAP->SNAP are SAMPLE_DIV cycles.
  assign w_tc_val     = (r_state == CLEAR) ? 32'(CLR_CYCLES - 1) : 32'(SAMPLE_DIV - 2);
  assign w_snap       = (r_state == SNAP);

  enc_sample_timer #(.W(32)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_timer_load),
    .i_inc    (w_timer_inc),
    .i_tc_val (w_tc_val),
    .o_tc     (w_tc)
  );

  // Scheduler FSM with its registered decoder controls and irq pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_clr_n <= 1'b0;
      r_irq   <= 1'b0;
    end else if (!i_en) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_clr_n <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= CLEAR;
          r_start <= 1'b0;
          r_clr_n <= 1'b0;
          r_irq   <= 1'b0;
        end
        CLEAR: begin
          if (w_tc) begin
            r_state <= ARM;
            r_start <= 1'b1;
            r_clr_n <= 1'b1;
          end else begin
            r_state <= CLEAR;
            r_start <= 1'b0;
            r_clr_n <= 1'b0;
          end
          r_irq <= 1'b0;
        end
        ARM: begin
          r_state <= RUN;
          r_start <= 1'b1;
          r_clr_n <= 1'b1;
          r_irq   <= 1'b0;
        end
        RUN: begin
          if (w_tc) begin
            r_state <= SNAP;
            r_irq   <= 1'b1;
          end else begin
            r_state <= RUN;
            r_irq   <= 1'b0;
          end
          r_start <= 1'b1;
          r_clr_n <= 1'b1;
        end
        SNAP: begin
          r_state <= RUN;
          r_start <= 1'b1;
          r_clr_n <= 1'b1;
          r_irq   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_start <= 1'b0;
          r_clr_n <= 1'b0;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  // Sequence counter and snapshot flags; a snapshot beats a coinciding status-read clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= 16'd0;
      r_sv  <= 1'b0;
      r_ovr <= 1'b0;
    end else if (w_snap) begin
      r_seq <= r_seq + 16'd1;
      r_sv  <= 1'b1;
      r_ovr <= r_stat_clr ? r_sv : (r_ovr | r_sv);
    end else if (r_stat_clr) begin
      r_seq <= r_seq;
      r_sv  <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_seq <= r_seq;
      r_sv  <= r_sv;
      r_ovr <= r_ovr;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [31:0] r_pos;
    logic [31:0] r_prev;
    logic [31:0] r_delta;
    logic [31:0] w_din;

    assign w_din = i_enc_dout[32*g +: 32];

    // Per-channel snapshot; prev is zeroed at ARM because the decoders restart from 0
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pos   <= 32'd0;
        r_prev  <= 32'd0;
        r_delta <= 32'd0;
      end else if (w_snap) begin
        r_pos   <= w_din;
        r_delta <= w_din - r_prev;
        r_prev  <= w_din;
      end else if (r_state == ARM) begin
        r_pos   <= r_pos;
        r_prev  <= 32'd0;
        r_delta <= r_delta;
      end else begin
        r_pos   <= r_pos;
        r_prev  <= r_prev;
        r_delta <= r_delta;
      end
    end

    assign w_pos[g]   = r_pos;
    assign w_delta[g] = r_delta;
  end

  assign w_pidx = IW'(i_rd_addr - 8'(ADDR_POS0));
  assign w_didx = IW'(i_rd_addr - addr_delta0(NUM_CH));

  // Read address decode
  always_comb begin
    w_rd_mux = 32'd0;
    if (i_rd_addr < addr_delta0(NUM_CH)) begin
      w_rd_mux = w_pos[w_pidx];
    end else if (i_rd_addr < addr_status(NUM_CH)) begin
      w_rd_mux = w_delta[w_didx];
    end else if (i_rd_addr == addr_status(NUM_CH)) begin
      w_rd_mux = pack_status(r_seq, r_state, r_ovr, r_sv);
    end else begin
      w_rd_mux = 32'd0;
    end
  end

  // Registered read port; r_stat_clr marks the ack cycle of a status read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= 32'd0;
      r_rd_ack   <= 1'b0;
      r_stat_clr <= 1'b0;
    end else if (i_rd_req) begin
      r_rd_data  <= w_rd_mux;
      r_rd_ack   <= 1'b1;
      r_stat_clr <= (i_rd_addr == addr_status(NUM_CH));
    end else begin
      r_rd_data  <= 32'd0;
      r_rd_ack   <= 1'b0;
      r_stat_clr <= 1'b0;
    end
  end

  assign o_enc_start    = {NUM_CH{r_start}};
  assign o_enc_clr_n    = {NUM_CH{r_clr_n}};
  assign o_rd_data      = r_rd_data;
  assign o_rd_ack       = r_rd_ack;
  assign o_sample_valid = r_sv;
  assign o_overrun      = r_ovr;
  assign o_irq          = r_irq;

endmodule

// File: tb/tb_enc_sample_sched.sv
// Directed self-checking bench for enc_sample_sched (NUM_CH=4, SAMPLE_DIV=10, CLR_CYCLES=4).
module tb_enc_sample_sched;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [127:0] enc_dout;
  logic [3:0]   enc_start;
  logic [3:0]   enc_clr_n;
  logic         rd_req;
  logic [7:0]   rd_addr;
  logic [31:0]  rd_data;
  logic         rd_ack;
  logic         sample_valid;
  logic         overrun;
  logic         irq;

  int checks;
  int failures;
  int n;

  enc_sample_sched #(.NUM_CH(4), .SAMPLE_DIV(10), .CLR_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (en),
    .i_enc_dout     (enc_dout),
    .o_enc_start    (enc_start),
    .o_enc_clr_n    (enc_clr_n),
    .i_rd_req       (rd_req),
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data),
    .o_rd_ack       (rd_ack),
    .o_sample_valid (sample_valid),
    .o_overrun      (overrun),
    .o_irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    enc_dout[32*k +: 32] = v;
  endtask

  // Advance until irq is seen (bounded); returns the number of ticks taken
  task automatic wait_snap(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!irq && cnt < 40);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req  = 1'b0;
    check_eq({tag, "_ack"}, 32'(rd_ack), 32'd1);
    check_eq(tag, rd_data, exp);
  endtask

  // en=1 from IDLE: four cycles of Clr, then ARM drives Start and releases Clr
  task automatic start_seq(input string tag);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq({tag, "_clr_low"}, 32'(enc_clr_n), 32'h0);
    end
    tick();
    check_eq({tag, "_clr_high"}, 32'(enc_clr_n), 32'hF);
    check_eq({tag, "_start"}, 32'(enc_start), 32'hF);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    enc_dout = 128'd0;
    rd_req   = 1'b0;
    rd_addr  = 8'd0;
    repeat (3) tick();
    check_eq("rst_clr_n", 32'(enc_clr_n), 32'h0);
    check_eq("rst_start", 32'(enc_start), 32'h0);
    check_eq("rst_sv", 32'(sample_valid), 32'd0);
    check_eq("rst_ack", 32'(rd_ack), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: start-up and period
    start_seq("t1");
    wait_snap(n);
    check_eq("t1_first_irq", 32'(n), 32'd10);
    set_ch(0, 32'd100); set_ch(1, 32'h7FFF_FFFF); set_ch(2, 32'd5); set_ch(3, 32'd0);
    tick();
    check_eq("t1_irq_pulse", 32'(irq), 32'd0);
    wait_snap(n);
    check_eq("t1_period", 32'(n), 32'd9);
    set_ch(0, 32'd250); set_ch(1, 32'h8000_0001); set_ch(2, 32'd3); set_ch(3, 32'h10);
    tick();

    // 3: two unread snapshots -> overrun; status read then clears
    check_eq("t3_sv", 32'(sample_valid), 32'd1);
    check_eq("t3_ovr", 32'(overrun), 32'd1);
    rd_req  = 1'b1;
    rd_addr = 8'd8;
    tick();
    check_eq("t3_stat_ack", 32'(rd_ack), 32'd1);
    check_eq("t3_status", rd_data, 32'h0002_000F);
    // 2 and 6: back-to-back data reads (request held high)
    rd_addr = 8'd0;
    tick();
    check_eq("t2_pos0", rd_data, 32'd250);
    check_eq("t3_sv_clr", 32'(sample_valid), 32'd0);
    check_eq("t3_ovr_clr", 32'(overrun), 32'd0);
    rd_addr = 8'd4; tick(); check_eq("t2_delta0", rd_data, 32'd150);
    rd_addr = 8'd1; tick(); check_eq("t2_pos1", rd_data, 32'h8000_0001);
    rd_addr = 8'd5; tick(); check_eq("t2_delta1", rd_data, 32'd2);
    rd_addr = 8'd6; tick(); check_eq("t2_delta2_wrap", rd_data, 32'hFFFF_FFFE);
    rd_addr = 8'd7; tick(); check_eq("t2_delta3", rd_data, 32'h10);
    rd_addr = 8'hFF; tick();
    check_eq("t6_badaddr_ack", 32'(rd_ack), 32'd1);
    check_eq("t6_badaddr_data", rd_data, 32'd0);
    rd_req = 1'b0;

    // 4: status read acked in the SNAP cycle
    wait_snap(n);
    check_eq("t4_snap3_seen", 32'(irq), 32'd1);
    set_ch(0, 32'd400);
    tick();
    check_eq("t4_ack_idle", 32'(rd_ack), 32'd0);
    check_eq("t4_ovr0", 32'(overrun), 32'd0);
    repeat (8) tick();
    rd_req  = 1'b1;
    rd_addr = 8'd8;
    tick();
    rd_req  = 1'b0;
    check_eq("t4_in_snap", 32'(irq), 32'd1);
    check_eq("t4_status_old", rd_data, 32'h0003_000D);
    set_ch(0, 32'd500);
    tick();
    check_eq("t4_sv_kept", 32'(sample_valid), 32'd1);
    check_eq("t4_ovr_old_sv", 32'(overrun), 32'd1);

    // 5: disable mid-RUN, then restart
    repeat (3) tick();
    en = 1'b0;
    tick();
    check_eq("t5_start_off", 32'(enc_start), 32'h0);
    check_eq("t5_clr_low", 32'(enc_clr_n), 32'h0);
    rd(8'd8, 32'h0004_0003, "t5_status_idle");
    rd(8'd0, 32'd500, "t5_pos_kept");
    start_seq("t5");
    wait_snap(n);
    check_eq("t5_first_irq", 32'(n), 32'd10);
    set_ch(0, 32'd77); set_ch(1, 32'h20);
    tick();
    rd(8'd4, 32'd77, "t5_delta0_first");
    rd(8'd5, 32'h20, "t5_delta1_first");
    rd(8'd0, 32'd77, "t5_pos0");

    // 6: reset asserted in the SNAP cycle
    wait_snap(n);
    check_eq("t6_snap_seen", 32'(irq), 32'd1);
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_irq", 32'(irq), 32'd0);
    check_eq("t6_rst_start", 32'(enc_start), 32'h0);
    check_eq("t6_rst_clr_n", 32'(enc_clr_n), 32'h0);
    check_eq("t6_rst_sv", 32'(sample_valid), 32'd0);
    check_eq("t6_rst_ovr", 32'(overrun), 32'd0);
    check_eq("t6_rst_ack", 32'(rd_ack), 32'd0);
    check_eq("t6_rst_data", rd_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(8'd0, 32'd0, "t6_pos_cleared");
    rd(8'd8, 32'd0, "t6_status_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
